// File: rtl/uart_mem_cmd_parser.sv
// uart_mem_cmd_parser
// Assembles host bytes from the serial receive path into 64-bit memory
// write/read requests, issues them over a req/ack handshake, and returns
// either the read data (8 bytes, MSB first) or a write acknowledge 'K'.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   rx_valid, rx_data        received byte strobe and value
//   tx_valid, tx_data,
//   tx_ready                 byte stream to the transmitter (valid/ready)
//   mem_req, mem_we,
//   mem_addr, mem_wdata,
//   mem_ack                  memory request, held until acknowledged
//   mem_rvalid, mem_rdata    read data return
//   busy                     high whenever a frame is in progress
//   err                      one-cycle pulse on protocol error
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for an opcode byte
// ADDR     | collecting 3 address bytes, MSB first
// WDATA    | collecting 8 write-data bytes, MSB first
// ISSUE    | mem_req held until mem_ack
// WAIT_RD  | read accepted, waiting for mem_rvalid
// SEND     | streaming 8 read-data bytes to the transmitter
// REPLY    | holding a single reply byte ('K' or '?') until accepted
module uart_mem_cmd_parser #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_ISSUE, S_WAIT_RD, S_SEND, S_REPLY
  } state_t;

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [23:0]       addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              req_q, req_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    we_d       = we_q;
    req_d      = req_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          cnt_d = 3'd0;
          tmr_d = '0;
          if (rx_data == 8'h57 || rx_data == 8'h52) begin
            state_d = S_ADDR;
            we_d    = (rx_data == 8'h57);
          end else begin
            state_d    = S_REPLY;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h3F;
            err_d      = 1'b1;
          end
        end
      end
      S_ADDR, S_WDATA: begin
        // A byte on the expiry cycle takes priority and restarts the timer.
        if (rx_valid) begin
          tmr_d = '0;
          cnt_d = cnt_q + 3'd1;
          if (state_q == S_ADDR) begin
            addr_d = {addr_q[15:0], rx_data};
            if (cnt_q == 3'd2) begin
              cnt_d = 3'd0;
              if (we_q) begin
                state_d = S_WDATA;
              end else begin
                state_d = S_ISSUE;
                req_d   = 1'b1;
              end
            end
          end else begin
            wdata_d = {wdata_q[55:0], rx_data};
            if (cnt_q == 3'd7) begin
              cnt_d   = 3'd0;
              state_d = S_ISSUE;
              req_d   = 1'b1;
            end
          end
        end else if (tmr_q == TMR_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmr_d   = '0;
          cnt_d   = 3'd0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_ISSUE, S_WAIT_RD: begin
        err_d = rx_valid;
        if (state_q == S_ISSUE && mem_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d    = S_REPLY;
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h4B;
          end else if (!mem_rvalid) begin
            state_d = S_WAIT_RD;
          end
        end
        // Read data may arrive together with the ack; skip WAIT_RD then.
        if (mem_rvalid && !we_q && (state_q == S_WAIT_RD || mem_ack)) begin
          state_d    = S_SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = mem_rdata[63:56];
          rdata_d    = {mem_rdata[55:0], 8'h00};
          cnt_d      = 3'd0;
        end
      end
      S_SEND: begin
        err_d = rx_valid;
        if (tx_ready) begin
          if (cnt_q == 3'd7) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            cnt_d      = 3'd0;
          end else begin
            tx_data_d = rdata_q[63:56];
            rdata_d   = {rdata_q[55:0], 8'h00};
            cnt_d     = cnt_q + 3'd1;
          end
        end
      end
      S_REPLY: begin
        err_d = rx_valid;
        if (tx_ready) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      tmr_q      <= '0;
      addr_q     <= 24'h0;
      wdata_q    <= 64'h0;
      rdata_q    <= 64'h0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      req_q      <= req_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_mem_cmd_parser.sv
module tb_uart_mem_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'h0;
  logic        busy;
  logic        err;

  int tests = 0;
  int fails = 0;
  int reqhi_cnt = 0;
  int ack_cnt = 0;
  int cyc;
  int r0;

  uart_mem_cmd_parser #(.ADDR_W(24), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req) reqhi_cnt++;
    if (mem_req && mem_ack) ack_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    send_byte(op);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic send_data(input logic [63:0] d);
    for (int k = 0; k < 8; k++) send_byte(d[63-8*k -: 8]);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_txv"}, tx_valid, 0);
    chk({tag, "_txd"}, tx_data, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Called right after the final data byte of a write frame.
  task automatic write_tail(input string tag, input logic [23:0] a, input logic [63:0] d);
    int acks;
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_addr"}, mem_addr, {40'h0, a});
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_busy"}, busy, 1);
    step(2);
    chk({tag, "_req_hold"}, mem_req, 1);
    acks = ack_cnt;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, "_one_ack"}, ack_cnt - acks, 1);
    chk({tag, "_req_drop"}, mem_req, 0);
    chk({tag, "_k_valid"}, tx_valid, 1);
    chk({tag, "_k_data"}, tx_data, 8'h4B);
    step(1);
    chk({tag, "_k_hold"}, tx_data, 8'h4B);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_done_txv"}, tx_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  task automatic recv_bytes(input string tag, input logic [63:0] exp, input bit rnd, output int ncyc);
    int i;
    bit stalled;
    logic [7:0] held;
    i = 0; ncyc = 0; stalled = 0; held = 8'h00;
    while (i < 8 && ncyc < 400) begin
      if (stalled) begin
        chk({tag, "_stall_valid"}, tx_valid, 1);
        chk({tag, "_stall_data"}, tx_data, held);
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        chk($sformatf("%s_byte%0d", tag, i), tx_data, exp[63-8*i -: 8]);
        i++;
        stalled = 0;
      end else begin
        stalled = tx_valid;
        held = tx_data;
      end
      @(negedge clk);
      ncyc++;
    end
    tx_ready = 1'b0;
    if (i < 8) chk({tag, "_recv_timeout"}, i, 8);
    chk({tag, "_end_txv"}, tx_valid, 0);
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    step(2);
    chk_reset("rst0");
    rst = 1'b0;
    step(1);

    // basic write
    send_hdr(8'h57, 24'h001234);
    send_data(64'h1122334455667788);
    write_tail("wr", 24'h001234, 64'h1122334455667788);

    // read, rvalid 5 cycles after ack, transmitter always ready
    send_hdr(8'h52, 24'h001234);
    chk("rd_req", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 24'h001234);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rd_req_drop", mem_req, 0);
    chk("rd_wait_txv", tx_valid, 0);
    chk("rd_wait_busy", busy, 1);
    step(4);
    mem_rvalid = 1'b1;
    mem_rdata = 64'hA1B2C3D4E5F60718;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rd_first_valid", tx_valid, 1);
    chk("rd_first_data", tx_data, 8'hA1);
    recv_bytes("rd", 64'hA1B2C3D4E5F60718, 1'b0, cyc);
    chk("rd_throughput", cyc, 8);

    // same read with a stalling transmitter
    send_hdr(8'h52, 24'h001234);
    chk("rdr_addr", mem_addr, 24'h001234);
    step(1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    step(4);
    mem_rvalid = 1'b1;
    mem_rdata = 64'hA1B2C3D4E5F60718;
    @(negedge clk);
    mem_rvalid = 1'b0;
    recv_bytes("rdr", 64'hA1B2C3D4E5F60718, 1'b1, cyc);

    // rvalid coincident with ack
    send_hdr(8'h52, 24'h00ABCD);
    mem_ack = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h0102030405060708;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    chk("rc_req", mem_req, 0);
    chk("rc_valid", tx_valid, 1);
    chk("rc_data", tx_data, 8'h01);
    recv_bytes("rc", 64'h0102030405060708, 1'b0, cyc);

    // invalid opcode
    r0 = reqhi_cnt;
    send_byte(8'h41);
    chk("inv_err", err, 1);
    chk("inv_valid", tx_valid, 1);
    chk("inv_data", tx_data, 8'h3F);
    chk("inv_busy", busy, 1);
    step(1);
    chk("inv_err_pulse", err, 0);
    chk("inv_hold", tx_valid, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("inv_valid_drop", tx_valid, 0);
    chk("inv_busy_drop", busy, 0);
    chk("inv_noreq", reqhi_cnt - r0, 0);

    // inter-byte timeout on a partial frame
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    step(15);
    chk("to_busy_before", busy, 1);
    chk("to_err_before", err, 0);
    step(1);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    step(1);
    chk("to_err_pulse", err, 0);
    send_hdr(8'h52, 24'h000001);
    chk("to_rd_req", mem_req, 1);
    chk("to_rd_we", mem_we, 0);
    chk("to_rd_addr", mem_addr, 24'h000001);
    mem_ack = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 64'h8877665544332211;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    recv_bytes("to_rd", 64'h8877665544332211, 1'b0, cyc);

    // byte arriving on the expiry cycle keeps the frame alive
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    step(15);
    send_byte(8'h05);
    chk("exp_err", err, 0);
    chk("exp_busy", busy, 1);
    send_data(64'hDEADBEEF01234567);
    write_tail("exp", 24'h000005, 64'hDEADBEEF01234567);

    // reset while mem_req is high
    send_hdr(8'h52, 24'h000777);
    chk("rr_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_req");
    rst = 1'b0;
    step(1);

    // reset while sending
    send_hdr(8'h52, 24'h000778);
    mem_ack = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 64'hCAFEBABE00000000;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    chk("rs_txv", tx_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_send");
    rst = 1'b0;
    step(1);

    // full write after reset
    send_hdr(8'h57, 24'h00ABCD);
    send_data(64'h0F0E0D0C0B0A0908);
    write_tail("post", 24'h00ABCD, 64'h0F0E0D0C0B0A0908);

    // bytes during WAIT_RD
    send_hdr(8'h52, 24'h000042);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    send_byte(8'h55);
    chk("wrx_err", err, 1);
    chk("wrx_busy", busy, 1);
    chk("wrx_txv", tx_valid, 0);
    send_byte(8'hAA);
    step(1);
    chk("wrx_err_pulse", err, 0);
    mem_rvalid = 1'b1;
    mem_rdata = 64'h0F1E2D3C4B5A6978;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("wrx_first", tx_data, 8'h0F);
    recv_bytes("wrx", 64'h0F1E2D3C4B5A6978, 1'b0, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_mem_cmd_parser.md
# uart_mem_cmd_parser

Byte-level command parser between the SPART receive/transmit path and the DDR SDRAM controller. It assembles serial bytes into 64-bit memory write and read requests and issues them over a req/ack handshake. It returns read data or a write acknowledge as bytes to the SPART transmit path, giving the host a simple memory peek/poke protocol over RS232.

## Interface
Parameters:
- ADDR_W, 24, memory word address width; always 3 address bytes on the wire, upper bits truncated if ADDR_W < 24
- TIMEOUT, 1000000, inter-byte timeout in clk cycles (10 ms at 100 MHz)

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous, active-high reset
- rx_valid  input  1  one-cycle pulse, rx_data holds a received byte
- rx_data  input  8  received byte
- tx_valid  output  1  tx_data holds a byte to transmit
- tx_data  output  8  byte to transmit
- tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready
- mem_req  output  1  memory request, held until acknowledged
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  64  write data
- mem_ack  input  1  controller accepted request (one-cycle pulse)
- mem_rvalid  input  1  one-cycle pulse, mem_rdata valid
- mem_rdata  input  64  read data
- busy  output  1  high in every state except IDLE
- err  output  1  one-cycle pulse on protocol error

## Operation
- Frame: opcode byte, then 3 address bytes MSB first; write frames add 8 data bytes MSB first (byte 0 → wdata[63:56]).
- Opcodes: 0x57 'W' write, 0x52 'R' read. Any other opcode: reply 0x3F '?', pulse err, no memory access.
- States: IDLE, ADDR, WDATA, ISSUE, WAIT_RD, SEND, REPLY.
- IDLE: on rx_valid, a valid opcode → ADDR with byte counter 0. An invalid opcode → REPLY with 0x3F.
- ADDR: shift in 3 bytes. The third byte goes to WDATA (write) or ISSUE (read).
- WDATA: shift in 8 bytes. The eighth byte goes to ISSUE.
- ISSUE: mem_req=1, with mem_we/mem_addr/mem_wdata stable. On mem_ack, write → REPLY with 0x4B 'K'; read → WAIT_RD. If mem_rvalid arrives in the same cycle as mem_ack, capture the data and go directly to SEND.
- WAIT_RD: on mem_rvalid, capture mem_rdata into a 64-bit shift register → SEND.
- SEND: transmit 8 bytes MSB first, one per tx handshake. After the 8th accepted byte → IDLE. Read frames send no 'K'.
- REPLY: hold tx_valid with the reply byte until accepted → IDLE.
- Timeout: the counter runs only in ADDR and WDATA and clears on each rx_valid. When it reaches TIMEOUT-1: go to IDLE, pulse err, discard the partial frame. If rx_valid and expiry occur in the same cycle, the byte wins and the counter clears.
- Bytes arriving in ISSUE, WAIT_RD, SEND or REPLY are dropped and err pulses. The state is unaffected.
- There is no timeout on memory wait states; the controller guarantees a response.

## Timing
- Reset values: tx_valid 0, tx_data 0x00, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, err 0. State is IDLE; the counter and shift registers are 0.
- Reset mid-operation takes effect on the next clk edge: mem_req and tx_valid drop immediately, and any pending request is abandoned.
- Final frame byte at cycle N → mem_req=1 at N+1.
- mem_ack at cycle M, write → mem_req=0 and tx_valid=1 with tx_data=0x4B at M+1.
- mem_ack at cycle M, read → mem_req=0 at M+1.
- mem_rvalid at cycle R → tx_valid=1 with tx_data=rdata[63:56] at R+1.
- Handshake at cycle T in SEND → the next byte is presented at T+1. tx_valid stays high between bytes when the transmitter is ready, giving a back-to-back throughput of 1 byte per cycle.
- tx_data must not change while tx_valid && !tx_ready.
- Invalid opcode at cycle N → err=1 at N+1 and tx_valid=1 with 0x3F at N+1.
- busy rises the cycle after the opcode is accepted and falls the cycle after the final tx handshake.

## Test plan
- Write: send 57 00 12 34 11 22 33 44 55 66 77 88; ack 3 cycles after req → one request with mem_we=1, mem_addr=0x001234, mem_wdata=0x1122334455667788, then one tx byte 0x4B.
- Read: send 52 00 12 34; ack, then mem_rvalid 5 cycles later with 0xA1B2C3D4E5F60718 → mem_we=0, addr 0x001234; tx bytes A1 B2 C3 D4 E5 F6 07 18 in order. Repeat with tx_ready toggling randomly; the sequence must be unchanged and tx_data stable while stalled.
- Read where mem_rvalid coincides with mem_ack → no WAIT_RD cycle; the first tx byte appears the next cycle.
- Invalid opcode 0x41 → err pulse, reply 0x3F, no mem_req, busy returns to 0.
- Send 57 00 00, then idle for TIMEOUT cycles (use TIMEOUT=16 in the bench) → err pulse and IDLE. A following 52 00 00 01 produces a read of address 0x000001. A byte arriving exactly on the expiry cycle keeps the frame alive.
- Assert rst while mem_req=1 and while in SEND → all outputs at reset values next cycle. A subsequent full write frame completes normally. Bytes sent during WAIT_RD pulse err and do not corrupt the returned data.
